// File: rtl/up_down_sequence_checker.sv
// Launches one run of an external up/down counter and verifies it steps 0..MAX_VALUE..0,
// reporting a pass flag, a saturating error count and the peak value observed.
module up_down_sequence_checker #(
  parameter int WIDTH         = 4,
  parameter int MAX_VALUE     = 15,
  parameter int START_TIMEOUT = 4
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_arm,
  input  logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_start,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_pass,
  output logic [7:0]       out_error_count,
  output logic [WIDTH-1:0] out_peak
);

  localparam int WDOG_LIMIT = 4 * (MAX_VALUE + 1) + 8;
  localparam int WDOG_W     = $clog2(WDOG_LIMIT + 1);
  localparam int TMO_W      = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT + 1);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_RUN, UP, DOWN, WAIT_IDLE, DONE
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  prev_q;
  logic [WIDTH-1:0]  peak_q;
  logic [7:0]        errCount_q;
  logic              pass_q;
  logic              start_q;
  logic              busy_q;
  logic              done_q;
  logic [WDOG_W-1:0] wdog_q;
  logic [TMO_W-1:0]  timeout_q;

  // Step checks are one bit wider so a wrap (MAX->MAX+1 overflow, 0->all-ones) never matches.
  logic [WIDTH:0] upExpect_d;
  logic [WIDTH:0] downExpect_d;
  logic           upOk_d;
  logic           downOk_d;
  logic           running_d;
  logic           wdogHit_d;
  logic [7:0]     errCount_d;

  assign upExpect_d   = {1'b0, prev_q} + (WIDTH+1)'(1);
  assign downExpect_d = {1'b0, prev_q} - (WIDTH+1)'(1);
  assign upOk_d       = ({1'b0, in_value} == upExpect_d);
  assign downOk_d     = ({1'b0, in_value} == downExpect_d);
  assign errCount_d   = (errCount_q == 8'hFF) ? errCount_q : errCount_q + 8'd1;
  assign running_d    = (state_q != IDLE) && (state_q != DONE);
  assign wdogHit_d    = running_d && (wdog_q == WDOG_W'(WDOG_LIMIT));

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      peak_q     <= '0;
      errCount_q <= '0;
      pass_q     <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wdog_q     <= '0;
      timeout_q  <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (running_d) wdog_q <= wdog_q + WDOG_W'(1);
      // The watchdog pre-empts whatever the current state would have checked this cycle.
      if (wdogHit_d) begin
        errCount_q <= errCount_d;
        pass_q     <= 1'b0;
        done_q     <= 1'b1;
        state_q    <= DONE;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_arm && in_ready) begin
              state_q    <= LAUNCH;
              start_q    <= 1'b1;
              busy_q     <= 1'b1;
              errCount_q <= '0;
              peak_q     <= '0;
              pass_q     <= 1'b1;
              wdog_q     <= WDOG_W'(1);
              timeout_q  <= '0;
            end
          end
          LAUNCH: state_q <= WAIT_RUN;
          WAIT_RUN: begin
            if (!in_ready) begin
              prev_q  <= in_value;
              state_q <= UP;
              if (in_value > peak_q) peak_q <= in_value;
              if (in_value != '0) begin
                errCount_q <= errCount_d;
                pass_q     <= 1'b0;
              end
            end else if (timeout_q == TMO_W'(START_TIMEOUT - 1)) begin
              errCount_q <= errCount_d;
              pass_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              timeout_q <= timeout_q + TMO_W'(1);
            end
          end
          UP, DOWN: begin
            if (in_ready) begin
              errCount_q <= errCount_d;
              pass_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              prev_q <= in_value;
              if (in_value > peak_q) peak_q <= in_value;
              if ((state_q == UP) ? !upOk_d : !downOk_d) begin
                errCount_q <= errCount_d;
                pass_q     <= 1'b0;
              end
              if (state_q == UP && in_value == MAX_V) begin
                state_q <= DOWN;
              end else if (state_q == DOWN && in_value == '0) begin
                state_q   <= WAIT_IDLE;
                timeout_q <= '0;
              end
            end
          end
          WAIT_IDLE: begin
            if (in_ready) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (timeout_q == TMO_W'(1)) begin
              errCount_q <= errCount_d;
              pass_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              timeout_q <= timeout_q + TMO_W'(1);
            end
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_start       = start_q;
  assign out_busy        = busy_q;
  assign out_done        = done_q;
  assign out_pass        = pass_q;
  assign out_error_count = errCount_q;
  assign out_peak        = peak_q;

endmodule

// File: tb/tb_up_down_sequence_checker.sv
// Bench for up_down_sequence_checker: directed and randomized counter runs on a 4-bit instance,
// plus an 8-bit instance that drives the error count into saturation.
module tb_up_down_sequence_checker;

  localparam int MAX0          = 15;
  localparam int MAX1          = 100;
  localparam int START_TIMEOUT = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] arm;
  logic [1:0] ready;
  logic [3:0] value0;
  logic [7:0] value1;
  logic       start0, start1, busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] errCnt0, errCnt1;
  logic [3:0] peak0;
  logic [7:0] peak1;
  logic [1:0] startV, busyV, doneV, passV;

  int checkCount = 0;
  int passCount  = 0;
  int trRdy[$];
  int trVal[$];

  always #5 clock = ~clock;

  assign startV = {start1, start0};
  assign busyV  = {busy1, busy0};
  assign doneV  = {done1, done0};
  assign passV  = {pass1, pass0};

  up_down_sequence_checker #(.WIDTH(4), .MAX_VALUE(MAX0), .START_TIMEOUT(START_TIMEOUT)) dut0 (
    .in_clock(clock), .in_reset(reset), .in_arm(arm[0]), .in_ready(ready[0]),
    .in_value(value0), .out_start(start0), .out_busy(busy0), .out_done(done0),
    .out_pass(pass0), .out_error_count(errCnt0), .out_peak(peak0)
  );

  up_down_sequence_checker #(.WIDTH(8), .MAX_VALUE(MAX1), .START_TIMEOUT(START_TIMEOUT)) dut1 (
    .in_clock(clock), .in_reset(reset), .in_arm(arm[1]), .in_ready(ready[1]),
    .in_value(value1), .out_start(start1), .out_busy(busy1), .out_done(done1),
    .out_pass(pass1), .out_error_count(errCnt1), .out_peak(peak1)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  function automatic int errOf(input int which);
    return (which == 0) ? int'(errCnt0) : int'(errCnt1);
  endfunction

  function automatic int peakOf(input int which);
    return (which == 0) ? int'(peak0) : int'(peak1);
  endfunction

  function automatic int rdyAt(input int s);
    return (s < trRdy.size()) ? trRdy[s] : 1;
  endfunction

  function automatic int valAt(input int s);
    return (s < trVal.size()) ? trVal[s] : 0;
  endfunction

  // Run-level reference: walks the sampled trace (index 0 = first cycle after launch) through
  // lead-in, rising, falling and tail segments; endIdx is the sample on which the run finishes.
  function automatic void modelRun(input int maxV, output int errs, output int peak,
                                   output int endIdx);
    int s, prev, v, lim;
    bit turned;
    errs = 0; peak = 0; endIdx = -1; s = 0;
    lim = 4 * (maxV + 1) + 8 - 2;
    while (rdyAt(s) == 1) begin
      if (s + 1 == START_TIMEOUT) begin errs = 1; endIdx = s; return; end
      s++;
    end
    v = valAt(s);
    if (v != 0) errs++;
    prev = v; if (v > peak) peak = v;
    s++;
    for (int dir = 1; dir >= -1; dir -= 2) begin
      turned = 1'b0;
      while (!turned) begin
        if (s == lim) begin errs++; endIdx = s; return; end
        if (rdyAt(s) == 1) begin errs++; endIdx = s; return; end
        v = valAt(s);
        if (v != prev + dir) errs++;
        prev = v; if (v > peak) peak = v;
        s++;
        turned = (v == ((dir > 0) ? maxV : 0));
      end
    end
    for (int t = 0; t < 2; t++) begin
      if (s == lim) begin errs++; endIdx = s; return; end
      if (rdyAt(s) == 1) begin endIdx = s; return; end
      s++;
    end
    errs++; endIdx = s - 1;
  endfunction

  task automatic pushSample(input int r, input int v);
    trRdy.push_back(r);
    trVal.push_back(v);
  endtask

  task automatic buildIdeal(input int maxV);
    trRdy.delete(); trVal.delete();
    for (int k = 0; k <= 2 * maxV; k++) pushSample(0, (k <= maxV) ? k : 2 * maxV - k);
  endtask

  task automatic buildRandom(input int maxV);
    int lead, tail, v, mode;
    trRdy.delete(); trVal.delete();
    lead = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
    repeat (lead) pushSample(1, $urandom_range(0, maxV));
    for (int k = 0; k <= 2 * maxV; k++) begin
      v = (k <= maxV) ? k : 2 * maxV - k;
      mode = $urandom_range(0, 39);
      if (mode < 3) v = $urandom_range(0, maxV);
      if (mode == 3) pushSample(1, 0);
      if (mode != 4) pushSample(0, v);
    end
    tail = $urandom_range(0, 3);
    repeat (tail) pushSample(0, 0);
  endtask

  task automatic driveSample(input int which, input int s);
    int r, v;
    r = rdyAt(s);
    v = valAt(s);
    ready[which] = r[0];
    if (which == 0) value0 = v[3:0];
    else value1 = v[7:0];
  endtask

  task automatic waitEvent(input int which, input bit forDone, input int limit,
                           output int n, output bit seen);
    seen = 1'b0;
    n = 0;
    while (!seen && n < limit) begin
      @(negedge clock);
      n++;
      seen = forDone ? doneV[which] : startV[which];
    end
  endtask

  task automatic applyStimulus(input int which, input int maxV, input string tag);
    int errs, pk, endIdx, j, n, budget;
    bit gotStart, gotDone;
    modelRun(maxV, errs, pk, endIdx);
    if (errs > 255) errs = 255;
    arm[which] = 1'b1;
    waitEvent(which, 1'b0, 8, n, gotStart);
    arm[which] = 1'b0;
    checkOutput({tag, " start seen"}, int'(gotStart), 1);
    if (!gotStart) return;
    budget = 4 * (maxV + 1) + 20;
    gotDone = 1'b0;
    j = 0;
    while (!gotDone && j < budget) begin
      @(negedge clock);
      j++;
      if (j == 1) begin
        checkOutput({tag, " start width"}, int'(startV[which]), 0);
        checkOutput({tag, " busy"}, int'(busyV[which]), 1);
      end
      gotDone = doneV[which];
      if (!gotDone) driveSample(which, j - 1);
    end
    ready[which] = 1'b1;
    checkOutput({tag, " done seen"}, int'(gotDone), 1);
    if (!gotDone) return;
    checkOutput({tag, " done cycle"}, j, endIdx + 2);
    checkOutput({tag, " pass"}, int'(passV[which]), int'(errs == 0));
    checkOutput({tag, " errors"}, errOf(which), errs);
    checkOutput({tag, " peak"}, peakOf(which), pk);
    @(negedge clock);
    checkOutput({tag, " done width"}, int'(doneV[which]), 0);
    checkOutput({tag, " busy after"}, int'(busyV[which]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int n, doneCount;
    bit seen;
    reset = 1'b1; arm = 2'b00; ready = 2'b11; value0 = '0; value1 = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset start", int'(start0), 0);
    checkOutput("reset busy", int'(busy0), 0);
    checkOutput("reset done", int'(done0), 0);
    checkOutput("reset pass", int'(pass0), 0);
    checkOutput("reset errors", int'(errCnt0), 0);
    checkOutput("reset peak", int'(peak0), 0);
    reset = 1'b0;
    @(negedge clock);

    buildIdeal(MAX0);
    applyStimulus(0, MAX0, "clean");
    buildIdeal(MAX0); trRdy.delete(3); trVal.delete(3);
    applyStimulus(0, MAX0, "skip");
    trRdy.delete(); trVal.delete();
    applyStimulus(0, MAX0, "no response");
    buildIdeal(MAX0);
    while (trRdy.size() > 8) begin void'(trRdy.pop_back()); void'(trVal.pop_back()); end
    pushSample(1, 0);
    applyStimulus(0, MAX0, "premature");
    trRdy.delete(); trVal.delete();
    repeat (80) pushSample(0, 3);
    applyStimulus(0, MAX0, "stuck");
    for (int r = 0; r < 25; r++) begin
      buildRandom(MAX0);
      applyStimulus(0, MAX0, $sformatf("random%0d", r));
    end

    trRdy.delete(); trVal.delete();
    arm[0] = 1'b1;
    waitEvent(0, 1'b0, 8, n, seen);
    checkOutput("b2b first start", int'(seen), 1);
    waitEvent(0, 1'b1, 12, n, seen);
    checkOutput("b2b done delay", n, 5);
    @(negedge clock);
    checkOutput("b2b idle gap", int'(busy0), 0);
    @(negedge clock);
    checkOutput("b2b relaunch", int'(start0), 1);
    arm[0] = 1'b0;
    waitEvent(0, 1'b1, 12, n, seen);
    checkOutput("b2b second done", int'(seen), 1);
    @(negedge clock);

    buildIdeal(MAX0);
    arm[0] = 1'b1;
    waitEvent(0, 1'b0, 8, n, seen);
    arm[0] = 1'b0;
    checkOutput("midreset start", int'(seen), 1);
    for (int s = 0; s <= 22; s++) begin
      @(negedge clock);
      driveSample(0, s);
    end
    @(negedge clock);
    checkOutput("midreset busy before", int'(busy0), 1);
    checkOutput("midreset peak before", int'(peak0), 15);
    reset = 1'b1;
    driveSample(0, 23);
    @(negedge clock);
    reset = 1'b0;
    ready[0] = 1'b1;
    checkOutput("midreset start", int'(start0), 0);
    checkOutput("midreset busy", int'(busy0), 0);
    checkOutput("midreset done", int'(done0), 0);
    checkOutput("midreset pass", int'(pass0), 0);
    checkOutput("midreset errors", int'(errCnt0), 0);
    checkOutput("midreset peak", int'(peak0), 0);
    doneCount = 0;
    repeat (6) begin
      @(negedge clock);
      if (done0) doneCount++;
    end
    checkOutput("midreset no done", doneCount, 0);
    buildIdeal(MAX0);
    applyStimulus(0, MAX0, "post-reset clean");

    trRdy.delete(); trVal.delete();
    repeat (430) pushSample(0, 3);
    applyStimulus(1, MAX1, "saturate");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
